// File: rtl/nic_rr_input_arbiter_pkg.sv
// Shared types and helpers for the NIC round-robin input arbiter.
package nic_rr_input_arbiter_pkg;

    // Arbiter control state: choosing a queue, or forwarding one packet from it.
    typedef enum logic {
        PICK      = 1'b0,
        IN_PACKET = 1'b1
    } arb_state_e;

    // Bits needed to hold a queue index; never less than one bit.
    function automatic int log2_ceil(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/nic_rr_input_arbiter_if.sv
// AXI4-Stream bundle with LANES packed streams side by side (lane i at slice i).
interface nic_rr_input_arbiter_if #(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128,
    parameter int LANES       = 1
);
    logic [LANES*DATA_WIDTH-1:0]   tdata;
    logic [LANES*DATA_WIDTH/8-1:0] tstrb;
    logic [LANES*TUSER_WIDTH-1:0]  tuser;
    logic [LANES-1:0]              tvalid;
    logic [LANES-1:0]              tlast;
    logic [LANES-1:0]              tready;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );
endinterface

// File: rtl/nic_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr_i, wrapping modulo N.
module nic_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic          found_o,
    output logic [PW-1:0] idx_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Scan from the farthest offset down to the pointer so the nearest request wins last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (PW + 1)'(k);
            if (sum >= (PW + 1)'(N)) begin
                sum = sum - (PW + 1)'(N);
            end
            cand = sum[PW-1:0];
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/nic_rr_input_arbiter.sv
// Packet-granular round-robin arbiter feeding the output port lookup from NUM_QUEUES RX streams.
module nic_rr_input_arbiter
    import nic_rr_input_arbiter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 4,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_resetn,
    nic_rr_input_arbiter_if.slave                s_axis,
    nic_rr_input_arbiter_if.master               m_axis,
    input  logic [NUM_QUEUES-1:0]                port_en,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]      pkt_cnt,
    output logic [log2_ceil(NUM_QUEUES)-1:0]     cur_grant
);

    localparam int PW = log2_ceil(NUM_QUEUES);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    arb_state_e                           state_q, state_d;
    logic [PW-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]                        grant_q, grant_d;
    logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [NUM_QUEUES-1:0] req;
    logic [NUM_QUEUES-1:0] s_ready;
    logic                  m_valid;
    logic                  pick_found;
    logic [PW-1:0]         pick_idx;

    assign req = s_axis.tvalid & port_en;

    nic_rr_pick #(
        .N  (NUM_QUEUES),
        .PW (PW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign m_axis.tdata  = s_axis.tdata[grant_q*DW +: DW];
    assign m_axis.tstrb  = s_axis.tstrb[grant_q*SW +: SW];
    assign m_axis.tuser  = s_axis.tuser[grant_q*UW +: UW];
    assign m_axis.tlast  = s_axis.tlast[grant_q];
    assign m_axis.tvalid = m_valid;
    assign s_axis.tready = s_ready;
    assign pkt_cnt       = pkt_cnt_q;
    assign cur_grant     = grant_q;

    // Next-state and handshake logic; the master port is idle while picking.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        m_valid   = 1'b0;
        s_ready   = '0;
        case (state_q)
            PICK: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = IN_PACKET;
                end
            end
            IN_PACKET: begin
                m_valid          = s_axis.tvalid[grant_q];
                s_ready[grant_q] = m_axis.tready;
                if (s_axis.tvalid[grant_q] && m_axis.tready && s_axis.tlast[grant_q]) begin
                    pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + CNT_WIDTH'(1);
                    rr_ptr_d = (grant_q == PW'(NUM_QUEUES - 1)) ? '0 : grant_q + PW'(1);
                    state_d  = PICK;
                end
            end
            default: state_d = PICK;
        endcase
    end

    // State, pointer, grant and counter registers; reset truncates any packet in flight.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q   <= PICK;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule
